// File: rtl/dev_mem_pkg.sv
// dev_mem_pkg: shared constants and types for the device memory arbiter, command parser and fetch engine
package dev_mem_pkg;
  localparam int DEF_ADDR_BITS = 14;
  localparam int DEF_DATA_BITS = 8;
  typedef enum logic [1:0] {S_IDLE, S_HOST, S_FETCH, S_FETCH_LAST} arb_state_t;
  typedef enum logic {REQ_HOST, REQ_FETCH} requester_t;
endpackage

// File: rtl/dev_mem_arbiter.sv
// dev_mem_arbiter: round-robin host/fetch arbiter for single-port device memory; DEV_MEM_ARB_STATS_EN adds stall/fetch counters
module dev_mem_arbiter
  import dev_mem_pkg::*;
#(
  parameter int ADDR_BITS = DEF_ADDR_BITS,
  parameter int DATA_BITS = DEF_DATA_BITS
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_host_req,
  input  logic                   i_host_we,
  input  logic [ADDR_BITS-1:0]   i_host_addr,
  input  logic [DATA_BITS-1:0]   i_host_wdata,
  output logic                   o_host_ack,
  output logic [DATA_BITS-1:0]   o_host_rdata,
  input  logic                   i_fetch_req,
  input  logic [ADDR_BITS-1:0]   i_fetch_addr,
  output logic                   o_fetch_ack,
  output logic [4*DATA_BITS-1:0] o_fetch_data,
`ifdef DEV_MEM_ARB_STATS_EN
  output logic [15:0]            o_host_stall_cnt,
  output logic [15:0]            o_fetch_cnt,
`endif
  output logic                   o_mem_en,
  output logic                   o_mem_we,
  output logic [ADDR_BITS-1:0]   o_mem_addr,
  output logic [DATA_BITS-1:0]   o_mem_wdata,
  input  logic [DATA_BITS-1:0]   i_mem_rdata
);
  arb_state_t               state;
  requester_t               last_grant;
  logic [ADDR_BITS-1:2]     base;
  logic [1:0]               beat;
  logic                     host_we;
  logic [3*DATA_BITS-1:0]   lanes;
  logic                     idle, host_g, fetch_g, beat_issue;
  logic                     unused;
  assign unused     = ^i_fetch_addr[1:0];
  assign idle       = state == S_IDLE && !i_rst;
  assign host_g     = idle && i_host_req && (!i_fetch_req || last_grant == REQ_FETCH);
  assign fetch_g    = idle && i_fetch_req && !host_g;
  assign beat_issue = state == S_FETCH && !i_rst;
  assign o_host_ack  = state == S_HOST && !i_rst;
  assign o_fetch_ack = state == S_FETCH_LAST && !i_rst;
  always_comb begin
    o_mem_en    = host_g || fetch_g || beat_issue;
    o_mem_we    = host_g && i_host_we;
    o_mem_addr  = host_g ? i_host_addr :
                  fetch_g ? {i_fetch_addr[ADDR_BITS-1:2], 2'b00} :
                  beat_issue ? {base, beat} : '0;
    o_mem_wdata = (host_g && i_host_we) ? i_host_wdata : '0;
  end
  // lanes shifts in bytes 0..2 so byte 3 can be appended straight from memory on the last cycle
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= S_IDLE;
      last_grant   <= REQ_FETCH;
      base         <= '0;
      beat         <= '0;
      host_we      <= 1'b0;
      lanes        <= '0;
      o_host_rdata <= '0;
      o_fetch_data <= '0;
    end else if (host_g) begin
      state      <= S_HOST;
      last_grant <= REQ_HOST;
      host_we    <= i_host_we;
    end else if (fetch_g) begin
      state      <= S_FETCH;
      last_grant <= REQ_FETCH;
      base       <= i_fetch_addr[ADDR_BITS-1:2];
      beat       <= 2'd1;
    end else if (state == S_HOST) begin
      state <= S_IDLE;
      if (!host_we) o_host_rdata <= i_mem_rdata;
    end else if (state == S_FETCH) begin
      lanes <= {i_mem_rdata, lanes[3*DATA_BITS-1:DATA_BITS]};
      beat  <= beat + 2'd1;
      if (beat == 2'd3) state <= S_FETCH_LAST;
    end else if (state == S_FETCH_LAST) begin
      o_fetch_data <= {i_mem_rdata, lanes};
      state        <= S_IDLE;
    end
  end
`ifdef DEV_MEM_ARB_STATS_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_host_stall_cnt <= '0;
      o_fetch_cnt      <= '0;
    end else begin
      if (i_host_req && !host_g && state != S_HOST && o_host_stall_cnt != 16'hFFFF)
        o_host_stall_cnt <= o_host_stall_cnt + 16'd1;
      if (o_fetch_ack && o_fetch_cnt != 16'hFFFF)
        o_fetch_cnt <= o_fetch_cnt + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_dev_mem_arbiter.sv
// tb_dev_mem_arbiter: table-driven and directed checks of dev_mem_arbiter against a byte memory model
module tb_dev_mem_arbiter;
  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_host_req = 1'b0, i_host_we = 1'b0;
  logic [13:0] i_host_addr = '0;
  logic [7:0]  i_host_wdata = '0;
  logic        o_host_ack;
  logic [7:0]  o_host_rdata;
  logic        i_fetch_req = 1'b0;
  logic [13:0] i_fetch_addr = '0;
  logic        o_fetch_ack;
  logic [31:0] o_fetch_data;
  logic        o_mem_en, o_mem_we;
  logic [13:0] o_mem_addr;
  logic [7:0]  o_mem_wdata;
  logic [7:0]  i_mem_rdata = '0;
`ifdef DEV_MEM_ARB_STATS_EN
  logic [15:0] o_host_stall_cnt, o_fetch_cnt;
`endif
  int pass_cnt = 0;
  int total = 0;
  logic [7:0] mem [0:16383];

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk)
    if (o_mem_en) begin
      if (o_mem_we) mem[o_mem_addr] <= o_mem_wdata;
      else i_mem_rdata <= mem[o_mem_addr];
    end

  dev_mem_arbiter dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_host_req(i_host_req), .i_host_we(i_host_we), .i_host_addr(i_host_addr),
    .i_host_wdata(i_host_wdata), .o_host_ack(o_host_ack), .o_host_rdata(o_host_rdata),
    .i_fetch_req(i_fetch_req), .i_fetch_addr(i_fetch_addr), .o_fetch_ack(o_fetch_ack),
    .o_fetch_data(o_fetch_data),
`ifdef DEV_MEM_ARB_STATS_EN
    .o_host_stall_cnt(o_host_stall_cnt), .o_fetch_cnt(o_fetch_cnt),
`endif
    .o_mem_en(o_mem_en), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .i_mem_rdata(i_mem_rdata)
  );

  typedef struct {
    logic        f;
    logic        we;
    logic [13:0] addr;
    logic [7:0]  wd;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h want %0h", name, act, exp);
  endtask

  task automatic do_reset;
    i_rst = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0;
  endtask

  task automatic host_txn(input logic we, input logic [13:0] addr, input logic [7:0] wd,
                          input logic [7:0] exp, input string name);
    int g = -1;
    int a = -1;
    logic gwe = 1'b0;
    logic stray = 1'b0;
    i_host_req = 1'b1; i_host_we = we; i_host_addr = addr; i_host_wdata = wd;
    for (int c = 0; c < 12 && a < 0; c++) begin
      #1;
      if (o_host_ack) begin a = c; i_host_req = 1'b0; end
      else if (o_mem_en && g < 0) begin g = c; gwe = o_mem_we; end
      else if (o_mem_we) stray = 1'b1;
      @(negedge i_clk);
    end
    i_host_req = 1'b0;
    #1;
    chk({name, "_lat"}, a - g, 1);
    chk({name, "_we"}, gwe, we);
    chk({name, "_stray_we"}, stray, 0);
    if (!we) chk({name, "_rdata"}, o_host_rdata, exp);
  endtask

  task automatic fetch_txn(input logic [13:0] addr, input logic [31:0] exp, input string name);
    int g = -1;
    int a = -1;
    logic stray = 1'b0;
    i_fetch_req = 1'b1; i_fetch_addr = addr;
    for (int c = 0; c < 12 && a < 0; c++) begin
      #1;
      if (o_fetch_ack) begin a = c; i_fetch_req = 1'b0; end
      else if (o_mem_en && g < 0) g = c;
      if (o_mem_we) stray = 1'b1;
      @(negedge i_clk);
    end
    i_fetch_req = 1'b0;
    #1;
    chk({name, "_lat"}, a - g, 4);
    chk({name, "_stray_we"}, stray, 0);
    chk({name, "_data"}, o_fetch_data, exp);
  endtask

  task automatic contend(input int exp_h, input int exp_f, input string name);
    int ha = -1;
    int fa = -1;
    i_host_req = 1'b1; i_host_we = 1'b0; i_host_addr = 14'h0010;
    i_fetch_req = 1'b1; i_fetch_addr = 14'h0100;
    for (int c = 0; c < 20 && (ha < 0 || fa < 0); c++) begin
      #1;
      if (o_host_ack) begin ha = c; i_host_req = 1'b0; end
      if (o_fetch_ack) begin fa = c; i_fetch_req = 1'b0; end
      @(negedge i_clk);
    end
    i_host_req = 1'b0; i_fetch_req = 1'b0;
    #1;
    chk({name, "_host_ack"}, ha, exp_h);
    chk({name, "_fetch_ack"}, fa, exp_f);
    chk({name, "_fetch_data"}, o_fetch_data, 32'h44332211);
  endtask

  initial begin
    tbl[0]  = '{0, 1, 14'h0010, 8'hA5, 32'h0};
    tbl[1]  = '{0, 0, 14'h0010, 8'h00, 32'hA5};
    tbl[2]  = '{0, 1, 14'h0100, 8'h11, 32'h0};
    tbl[3]  = '{0, 1, 14'h0101, 8'h22, 32'h0};
    tbl[4]  = '{0, 1, 14'h0102, 8'h33, 32'h0};
    tbl[5]  = '{0, 1, 14'h0103, 8'h44, 32'h0};
    tbl[6]  = '{1, 0, 14'h0102, 8'h00, 32'h44332211};
    tbl[7]  = '{0, 0, 14'h0101, 8'h00, 32'h22};
    tbl[8]  = '{0, 1, 14'h3FFC, 8'hDE, 32'h0};
    tbl[9]  = '{0, 1, 14'h3FFD, 8'hAD, 32'h0};
    tbl[10] = '{0, 1, 14'h3FFE, 8'hBE, 32'h0};
    tbl[11] = '{0, 1, 14'h3FFF, 8'hEF, 32'h0};
    tbl[12] = '{0, 1, 14'h0010, 8'h5A, 32'h0};
    tbl[13] = '{0, 0, 14'h0010, 8'h00, 32'h5A};

    repeat (2) @(negedge i_clk);
    i_rst = 1'b0;
    #1;
    chk("rst_host_ack", o_host_ack, 0);
    chk("rst_fetch_ack", o_fetch_ack, 0);
    chk("rst_host_rdata", o_host_rdata, 0);
    chk("rst_fetch_data", o_fetch_data, 0);
    chk("rst_mem_en", o_mem_en, 0);
    chk("rst_mem_we", o_mem_we, 0);
    chk("rst_mem_addr", o_mem_addr, 0);
    chk("rst_mem_wdata", o_mem_wdata, 0);

    for (int i = 0; i < 14; i++) begin
      if (tbl[i].f) fetch_txn(tbl[i].addr, tbl[i].exp, $sformatf("vec%0d", i));
      else host_txn(tbl[i].we, tbl[i].addr, tbl[i].wd, tbl[i].exp[7:0], $sformatf("vec%0d", i));
    end

    // host won last, so fetch wins this contention; afterwards reset restores host priority
    contend(6, 4, "rr_fetch_first");
    do_reset;
    contend(1, 6, "rr_after_reset");
    contend(1, 6, "rr_next");

    begin
      int ha = -1;
      int fa = -1;
      int hg = -1;
      i_fetch_req = 1'b1; i_fetch_addr = 14'h0100;
      for (int c = 0; c < 20 && (ha < 0 || fa < 0); c++) begin
        if (c == 1) begin
          i_host_req = 1'b1; i_host_we = 1'b1; i_host_addr = 14'h0200; i_host_wdata = 8'h77;
        end
        #1;
        if (o_fetch_ack) begin fa = c; i_fetch_req = 1'b0; end
        if (o_host_ack) begin ha = c; i_host_req = 1'b0; end
        if (o_mem_we && hg < 0) hg = c;
        @(negedge i_clk);
      end
      i_host_req = 1'b0; i_fetch_req = 1'b0;
      chk("burst_fetch_ack", fa, 4);
      chk("burst_host_grant", hg, 5);
      chk("burst_host_wait", ha - 1, 5);
    end
    host_txn(1'b0, 14'h0200, 8'h00, 8'h77, "burst_readback");

    begin
      logic seen = 1'b0;
      i_fetch_req = 1'b1; i_fetch_addr = 14'h0100;
      for (int c = 0; c < 3; c++) begin
        #1;
        if (o_fetch_ack) seen = 1'b1;
        if (c == 2) begin i_rst = 1'b1; i_fetch_req = 1'b0; end
        @(negedge i_clk);
      end
      #1;
      chk("midrst_fetch_data", o_fetch_data, 0);
      chk("midrst_host_rdata", o_host_rdata, 0);
      chk("midrst_mem_en", o_mem_en, 0);
      chk("midrst_acks", {o_host_ack, o_fetch_ack}, 0);
      i_rst = 1'b0;
      for (int c = 0; c < 6; c++) begin
        #1;
        if (o_fetch_ack) seen = 1'b1;
        @(negedge i_clk);
      end
      chk("midrst_no_ack", seen, 0);
    end
    fetch_txn(14'h3FFC, 32'hEFBEADDE, "top_word");

`ifdef DEV_MEM_ARB_STATS_EN
    do_reset;
    #1;
    chk("stats_rst_stall", o_host_stall_cnt, 0);
    chk("stats_rst_fetch", o_fetch_cnt, 0);
    host_txn(1'b1, 14'h0300, 8'h01, 8'h00, "stats_host");
    chk("stats_no_stall", o_host_stall_cnt, 0);
    contend(6, 4, "stats_contend");
    chk("stats_stall", o_host_stall_cnt, 5);
    chk("stats_fetch", o_fetch_cnt, 1);
    do_reset;
    #1;
    chk("stats_clr_stall", o_host_stall_cnt, 0);
    chk("stats_clr_fetch", o_fetch_cnt, 0);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
